rf_param: RTL and testbench

RF_PARAM -- requirements
Module: rf_param

---
 rtl/rf_param.sv | 100 ++++++++++
 tb/tb_rf_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_param.sv
// Parameterised register file with two combinational read ports, one write port
// and a one-entry-per-cycle clear sweep that runs after reset and on request.
module rf_param #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [XLEN-1:0]   WD3,
  input  logic              clr_req,
  output logic [XLEN-1:0]   RD1,
  output logic [XLEN-1:0]   RD2,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                wr_drop_q;
  logic                wr_drop_d;
  logic [XLEN-1:0]     mem_q [DEPTH];

  logic                in_clear_s;
  logic                wr_ok_s;
  logic                zero1_s;
  logic                zero2_s;
  logic                byp1_s;
  logic                byp2_s;

  assign in_clear_s = (state_q == CLEAR);
  assign wr_ok_s    = (state_q == READY) && WE3 && !clr_req
                      && !((ZERO_REG != 0) && (A3 == {ADDR_W{1'b0}}));
  // Any write arriving while clearing, or alongside an accepted clear, is lost.
  assign wr_drop_d  = WE3 && (in_clear_s || clr_req);

  // Sweep/ready sequencing and the registered drop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      ptr_q     <= {ADDR_W{1'b0}};
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
      case (state_q)
        CLEAR: begin
          if (ptr_q == LAST_PTR) begin
            state_q <= READY;
            ptr_q   <= {ADDR_W{1'b0}};
          end else begin
            ptr_q   <= ptr_q + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            state_q <= CLEAR;
            ptr_q   <= {ADDR_W{1'b0}};
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  // Storage is never reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (in_clear_s) begin
      mem_q[ptr_q] <= {XLEN{1'b0}};
    end else if (wr_ok_s) begin
      mem_q[A3] <= WD3;
    end
  end

  assign zero1_s = in_clear_s || ((ZERO_REG != 0) && (A1 == {ADDR_W{1'b0}}));
  assign zero2_s = in_clear_s || ((ZERO_REG != 0) && (A2 == {ADDR_W{1'b0}}));
  assign byp1_s  = (BYPASS != 0) && wr_ok_s && (A1 == A3);
  assign byp2_s  = (BYPASS != 0) && wr_ok_s && (A2 == A3);

  assign RD1     = zero1_s ? {XLEN{1'b0}} : (byp1_s ? WD3 : mem_q[A1]);
  assign RD2     = zero2_s ? {XLEN{1'b0}} : (byp2_s ? WD3 : mem_q[A2]);
  assign busy    = in_clear_s;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_rf_param.sv
// Scoreboard bench: two rf_param configurations share one random/directed stimulus
// stream; a reference model predicts every cycle's outputs, a monitor compares them.
module tb_rf_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3;
  logic        we, clr;
  logic [63:0] wd;

  logic [31:0] rd1_a, rd2_a;
  logic        busy_a, drop_a;
  logic [63:0] rd1_b, rd2_b;
  logic        busy_b, drop_b;

  always #5 clk = ~clk;

  rf_param dut_a (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .A3(a3), .WE3(we), .WD3(wd[31:0]),
    .clr_req(clr), .RD1(rd1_a), .RD2(rd2_a), .busy(busy_a), .wr_drop(drop_a)
  );

  rf_param #(.XLEN(64), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .A1(a1[2:0]), .A2(a2[2:0]), .A3(a3[2:0]), .WE3(we), .WD3(wd),
    .clr_req(clr), .RD1(rd1_b), .RD2(rd2_b), .busy(busy_b), .wr_drop(drop_b)
  );

  typedef struct {
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic        busy;
    logic        drop;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: per configuration, an array plus "sweep cycles remaining".
  int          depth_m [2] = '{32, 8};
  bit          byp_m   [2] = '{1'b1, 1'b0};
  bit          zr_m    [2] = '{1'b1, 1'b0};
  logic [63:0] mask_m  [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] mem_m   [2][32];
  int          left_m  [2];
  bit          drop_m  [2];

  logic [4:0]  p_a3;
  logic        p_we, p_clr, p_rst;
  logic [63:0] p_wd;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left_m[k] = depth_m[k];
      drop_m[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int wi;
      wi = int'(p_a3) % depth_m[k];
      if (p_rst) begin
        if (left_m[k] > 0) begin
          mem_m[k][depth_m[k] - left_m[k]] = 64'h0;
          left_m[k] = left_m[k] - 1;
          drop_m[k] = p_we;
        end else if (p_clr) begin
          left_m[k] = depth_m[k];
          drop_m[k] = p_we;
        end else begin
          drop_m[k] = 1'b0;
          if (p_we && !(zr_m[k] && wi == 0)) mem_m[k][wi] = p_wd & mask_m[k];
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_rd(input int k, input logic [4:0] a);
    int ai, wi;
    ai = int'(a) % depth_m[k];
    wi = int'(a3) % depth_m[k];
    if (left_m[k] > 0) return 64'h0;
    if (zr_m[k] && ai == 0) return 64'h0;
    if (byp_m[k] && we && !clr && !(zr_m[k] && wi == 0) && ai == wi) return wd & mask_m[k];
    return mem_m[k][ai];
  endfunction

  task automatic push_expect();
    exp_t e;
    e.rd1 = exp_rd(0, a1); e.rd2 = exp_rd(0, a2);
    e.busy = (left_m[0] > 0); e.drop = drop_m[0];
    qa.push_back(e);
    e.rd1 = exp_rd(1, a1); e.rd2 = exp_rd(1, a2);
    e.busy = (left_m[1] > 0); e.drop = drop_m[1];
    qb.push_back(e);
  endtask

  // One clock of stimulus; r pulls reset low mid-cycle, away from any clock edge.
  task automatic step(input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] x3,
                      input logic w, input logic [63:0] d, input logic c, input bit r);
    @(posedge clk);
    model_edge();
    #1;
    a1 = x1; a2 = x2; a3 = x3; we = w; wd = d; clr = c;
    if (r) begin
      #1;
      rst = 1'b0;
      model_reset();
    end else begin
      rst = 1'b1;
    end
    p_a3 = x3; p_we = w; p_wd = d; p_clr = c; p_rst = rst;
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(5'(i), 5'(31 - i), 5'(i), 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 32; i++)
      step(5'(i), 5'(i ^ 5), 5'd0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: pops one expectation per configuration at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("A.RD1", {32'h0, rd1_a}, e.rd1);
        chk("A.RD2", {32'h0, rd2_a}, e.rd2);
        chk("A.busy", {63'h0, busy_a}, {63'h0, e.busy});
        chk("A.wr_drop", {63'h0, drop_a}, {63'h0, e.drop});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("B.RD1", rd1_b, e.rd1);
        chk("B.RD2", rd2_b, e.rd2);
        chk("B.busy", {63'h0, busy_b}, {63'h0, e.busy});
        chk("B.wr_drop", {63'h0, drop_b}, {63'h0, e.drop});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; a1 = 5'd0; a2 = 5'd0; a3 = 5'd0; we = 1'b0; wd = 64'h0; clr = 1'b0;
    p_a3 = 5'd0; p_we = 1'b0; p_wd = 64'h0; p_clr = 1'b0; p_rst = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mem_m[k][i] = 64'h0;
    model_reset();

    // Reset, release, sweep with writes attempted during it, then read everything.
    for (int i = 0; i < 3; i++) step(5'd3, 5'd4, 5'd5, 1'b1, 64'h11, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++)
      step(5'(i), 5'(31 - i), 5'(i), (i % 5) == 0, 64'(i + 100), 1'b0, 1'b0);
    read_all();

    // Basic writes, read-back, write to entry 0.
    step(5'd0, 5'd0, 5'd5, 1'b1, 64'h5, 1'b0, 1'b0);
    step(5'd5, 5'd0, 5'd9, 1'b1, 64'h20, 1'b0, 1'b0);
    step(5'd5, 5'd9, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    step(5'd0, 5'd5, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    step(5'd0, 5'd9, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0);
    step(5'd0, 5'd8, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0);

    // Same-cycle forwarding (or not), then the settled value.
    step(5'd7, 5'd7, 5'd7, 1'b1, 64'h9, 1'b0, 1'b0);
    step(5'd7, 5'd7, 5'd7, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
    step(5'd7, 5'd15, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0);

    // Clear with a simultaneous write, a second request mid-sweep, then read all.
    step(5'd12, 5'd4, 5'd12, 1'b1, 64'h1234, 1'b0, 1'b0);
    step(5'd12, 5'd4, 5'd12, 1'b1, 64'hABC, 1'b1, 1'b0);
    idle(10);
    step(5'd12, 5'd1, 5'd3, 1'b0, 64'h0, 1'b1, 1'b0);
    idle(24);
    read_all();

    // Reset while the sweep pointer sits at 10, then a full sweep.
    step(5'd1, 5'd2, 5'd6, 1'b1, 64'h77, 1'b0, 1'b0);
    step(5'd6, 5'd2, 5'd0, 1'b0, 64'h0, 1'b1, 1'b0);
    idle(10);
    step(5'd6, 5'd2, 5'd4, 1'b1, 64'h55, 1'b0, 1'b1);
    step(5'd6, 5'd2, 5'd4, 1'b0, 64'h0, 1'b0, 1'b1);
    idle(34);
    read_all();

    // Random traffic, reads biased toward the write address, rare clears.
    for (int i = 0; i < 500; i++) begin
      logic [4:0] x1, x2, x3;
      x3 = 5'($urandom_range(0, 31));
      x1 = ($urandom_range(0, 2) == 0) ? x3 : 5'($urandom_range(0, 31));
      x2 = ($urandom_range(0, 2) == 0) ? x3 : 5'($urandom_range(0, 31));
      step(x1, x2, x3, $urandom_range(0, 3) != 0, {32'($urandom), 32'($urandom)},
           $urandom_range(0, 63) == 0, 1'b0);
    end
    idle(34);
    read_all();

    @(negedge clk);
    #1;
    n_total++;
    if (qa.size() == 0 && qb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
